// File: rtl/datapath_seq_ctrl_if.sv
// Host <-> sequencer bundle: run request, abort, iteration count, and the
// sequencer's datapath strobes plus busy/done/iteration status.
interface datapath_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_iter;
  logic             sel1;
  logic             sel2;
  logic             mux1;
  logic             acc_clr;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_idx;

  modport master (
    output start, abort, n_iter,
    input  sel1, sel2, mux1, acc_clr, acc_en, busy, done, iter_idx
  );

  modport slave (
    input  start, abort, n_iter,
    output sel1, sel2, mux1, acc_clr, acc_en, busy, done, iter_idx
  );
endinterface

// File: rtl/datapath_seq_ctrl.sv
// Multi-iteration sequencer for the two-operand select/mux datapath.
// Clears the accumulator, then repeats LD1/LD2/OP/ACC n_iter times and
// ends with a one-cycle done pulse. Abort returns to IDLE from any state.
module datapath_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  datapath_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LD1  = 3'd2,
    S_LD2  = 3'd3,
    S_OP   = 3'd4,
    S_ACC  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_n_lat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel1;
  logic             r_sel2;
  logic             r_mux1;
  logic             r_acc_clr;
  logic             r_acc_en;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0]   w_cnt_inc;
  logic             w_last;

  // One extra bit so n_lat = 2^CNT_W-1 compares without wrapping.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, r_n_lat});

  // Outputs are registered together with the state they belong to, so each
  // strobe is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_n_lat   <= '0;
      r_cnt     <= '0;
      r_sel1    <= 1'b0;
      r_sel2    <= 1'b0;
      r_mux1    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sel1    <= 1'b0;
      r_sel2    <= 1'b0;
      r_mux1    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      if ((r_state != S_IDLE) && bus.abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_busy <= 1'b1;
              if (bus.n_iter != '0) begin
                r_state   <= S_CLR;
                r_n_lat   <= bus.n_iter;
                r_cnt     <= '0;
                r_acc_clr <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_CLR: begin
            r_state <= S_LD1;
            r_sel1  <= 1'b1;
            r_busy  <= 1'b1;
          end
          S_LD1: begin
            r_state <= S_LD2;
            r_sel2  <= 1'b1;
            r_busy  <= 1'b1;
          end
          S_LD2: begin
            r_state <= S_OP;
            r_mux1  <= 1'b1;
            r_busy  <= 1'b1;
          end
          S_OP: begin
            r_state  <= S_ACC;
            r_acc_en <= 1'b1;
            r_busy   <= 1'b1;
          end
          S_ACC: begin
            r_busy <= 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LD1;
              r_cnt   <= w_cnt_inc[CNT_W-1:0];
              r_sel1  <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sel1     = r_sel1;
  assign bus.sel2     = r_sel2;
  assign bus.mux1     = r_mux1;
  assign bus.acc_clr  = r_acc_clr;
  assign bus.acc_en   = r_acc_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.iter_idx = r_cnt;

endmodule

// File: doc/datapath_seq_ctrl.md
# datapath_seq_ctrl

Multi-iteration sequencer for the two-operand select/mux datapath. On a `start` request it clears the accumulator, then runs the load-1 / load-2 / operate / accumulate sequence a programmable number of times. It finishes with a one-cycle `done` pulse. It replaces one-shot sequencing, adding an iteration counter, an abort path and a busy/done handshake for the upstream host.

## Interface
Parameters:
- `CNT_W`, 4: width of the iteration count and index; maximum iterations 2^CNT_W − 1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  cancel request; sampled in every non-IDLE state.
- `n_iter`  in  CNT_W  iteration count; latched when `start` is accepted.
- `sel1`  out  1  load operand 1 into the datapath.
- `sel2`  out  1  load operand 2 into the datapath.
- `mux1`  out  1  route the operation result.
- `acc_clr`  out  1  clear the accumulator.
- `acc_en`  out  1  accumulate the result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `iter_idx`  out  CNT_W  index of the current iteration, 0-based.

## Operation
- Moore FSM with states IDLE, CLR, LD1, LD2, OP, ACC, DONE.
- Outputs are decoded from the state register only. No input reaches an output combinationally.
- Internal registers: `n_lat` (CNT_W bits) and `cnt` (CNT_W bits), driven on `iter_idx`.

State transitions:
- IDLE:
  - `start`=1 and `n_iter`≠0 → CLR; latch `n_lat`=`n_iter`, `cnt`=0.
  - `start`=1 and `n_iter`=0 → DONE; no datapath strobes are issued.
  - Otherwise stay in IDLE.
- CLR: assert `acc_clr` → LD1.
- LD1: assert `sel1` → LD2.
- LD2: assert `sel2` → OP.
- OP: assert `mux1` → ACC.
- ACC: assert `acc_en`.
  - If `cnt`+1 == `n_lat` → DONE, and `cnt` holds.
  - Otherwise `cnt` ← `cnt`+1 and → LD1.
- DONE: assert `done`; `busy`=1 → IDLE.

Other rules:
- `abort`=1 in any state other than IDLE forces IDLE on the next edge. No `done` is produced. `cnt` and `n_lat` hold their values. Abort has priority over all other transitions, including in DONE.
- `start` is ignored in every state except IDLE. `n_iter` changes after acceptance have no effect.
- One-hot strobes: at most one of `sel1`, `sel2`, `mux1`, `acc_clr`, `acc_en` is high in any cycle.
- Illegal or unused state encodings → IDLE on the next edge, with all strobes 0.
- The `cnt`+1 compare is done at CNT_W+1 bits, so `n_lat`=2^CNT_W−1 completes without wrap.

## Timing
- Reset (`rst_n`=0): state goes to IDLE immediately, independent of `clk`.
  - All outputs 0: `sel1`, `sel2`, `mux1`, `acc_clr`, `acc_en`, `busy`, `done`, and `iter_idx`=0.
  - `n_lat` = 0.
- Reset mid-run discards the run. No `done` is produced.
- Cycle numbering: edge 0 samples `start` in IDLE.
  - CLR is cycle 1.
  - Iteration k (0-based) occupies cycles 2+4k to 5+4k, in the order LD1, LD2, OP, ACC.
  - DONE is cycle 4N+2.
  - IDLE resumes at cycle 4N+3, so a new `start` is accepted at the earliest at edge 4N+3.
- For N=0: DONE is cycle 1 and IDLE is cycle 2.
- `iter_idx` = k throughout iteration k. It updates on the edge that leaves ACC.
- `busy` rises in the cycle after `start` is accepted. It falls in the first IDLE cycle.
- `abort` sampled at edge t: IDLE and all strobes 0 from cycle t onward.

## Test plan
- Reset then idle: hold `rst_n`=0 mid-cycle → all outputs 0 asynchronously. Release, with `start`=0 for 10 cycles → `busy`=0, no strobes.
- Normal run: `n_iter`=3, pulse `start` → `acc_clr` in cycle 1; `sel1` in cycles 2/6/10, `sel2` in 3/7/11, `mux1` in 4/8/12, `acc_en` in 5/9/13; `iter_idx` reads 0, 1, 2; `done` only in cycle 14; `busy` in cycles 1–14.
- Zero count: `n_iter`=0, `start` → `done` in cycle 1, no strobes, IDLE in cycle 2.
- Abort: `n_iter`=5, assert `abort` at edge 7 → all strobes 0 and `busy`=0 from cycle 7; `done` never asserts. A new `start` with `n_iter`=1 then completes normally with `done` at relative cycle 6.
- Start ignored and input stability: pulse `start` again and change `n_iter` to 7 during a run with `n_iter`=2 → run completes after 2 iterations, `done` in cycle 10, no second run begins.
- Maximum count: CNT_W=4, `n_iter`=15 → 15 `acc_en` pulses, last `iter_idx`=14, `done` in cycle 62; the one-hot strobe check holds in every cycle.
